mem_arbiter: RTL

- Shares the single line-wide main-memory port between the instruction-cache miss path (fetch stage) and the data cache's miss-fill and writeback paths.
- Grants one transaction at a time, forwards it to memory, waits for completion, and routes the response back to the owning requester.
- Sits between the two caches and the memory model. Each cache sees a private req/res port, identical in shape to the one it would have with exclusive memory.

---
 rtl/mem_arbiter_pkg.sv | 55 +++++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter.
// State/owner encodings and requester indices.
package mem_arbiter_pkg;

  localparam int MEMARB_WORD_SIZE = 32;
  localparam int MEMARB_LINE_SIZE = 128;

  localparam int MEMARB_NREQ = 3;
  localparam int REQ_I  = 0;
  localparam int REQ_DR = 1;
  localparam int REQ_DW = 2;

  typedef enum logic [1:0] {
    MEMARB_IDLE,
    MEMARB_ISSUE,
    MEMARB_WAIT,
    MEMARB_RESP
  } memarb_state_t;

  typedef enum logic [1:0] {
    MEMARB_NONE,
    MEMARB_IFETCH,
    MEMARB_DREAD,
    MEMARB_DWRITE
  } memarb_owner_t;

  function automatic memarb_owner_t memarb_owner_of(
    input logic [MEMARB_NREQ-1:0] grant
  );
    memarb_owner_t o;
    o = MEMARB_NONE;
    if (grant[REQ_DW])
      o = MEMARB_DWRITE;
    else if (grant[REQ_DR])
      o = MEMARB_DREAD;
    else if (grant[REQ_I])
      o = MEMARB_IFETCH;
    return o;
  endfunction

  function automatic logic [MEMARB_NREQ-1:0] memarb_owner_bit(
    input memarb_owner_t o
  );
    logic [MEMARB_NREQ-1:0] b;
    b = '0;
    unique case (o)
      MEMARB_IFETCH: b[REQ_I]  = 1'b1;
      MEMARB_DREAD:  b[REQ_DR] = 1'b1;
      MEMARB_DWRITE: b[REQ_DW] = 1'b1;
      default:       b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selector: writeback first, then
// round-robin between ifetch and dcache read.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [MEMARB_NREQ-1:0] req,
  input  logic                   rr,
  output logic [MEMARB_NREQ-1:0] grant,
  output logic                   rr_next
);

  // rr=0 favours ifetch, rr=1 favours dcache read
  always_comb begin
    grant   = '0;
    rr_next = rr;
    if (req[REQ_DW]) begin
      grant[REQ_DW] = 1'b1;
    end else if (req[REQ_I] && req[REQ_DR]) begin
      if (rr)
        grant[REQ_DR] = 1'b1;
      else
        grant[REQ_I] = 1'b1;
    end else if (req[REQ_I]) begin
      grant[REQ_I] = 1'b1;
    end else if (req[REQ_DR]) begin
      grant[REQ_DR] = 1'b1;
    end
    if (grant[REQ_I])
      rr_next = 1'b1;
    if (grant[REQ_DR])
      rr_next = 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter shared by the
// icache miss path and dcache fill/writeback paths.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = MEMARB_WORD_SIZE,
  parameter int LINE_SIZE = MEMARB_LINE_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_req_addr,
  output logic                 i_res,
  output logic [WORD_SIZE-1:0] i_res_addr,
  output logic [LINE_SIZE-1:0] i_res_data,
  input  logic                 d_req,
  input  logic [WORD_SIZE-1:0] d_req_addr,
  output logic                 d_res,
  output logic [WORD_SIZE-1:0] d_res_addr,
  output logic [LINE_SIZE-1:0] d_res_data,
  input  logic                 d_wr,
  input  logic [WORD_SIZE-1:0] d_wr_addr,
  input  logic [LINE_SIZE-1:0] d_wr_data,
  output logic                 d_wr_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic                 mem_done,
  input  logic [LINE_SIZE-1:0] mem_rdata
);

  memarb_state_t state_q;
  memarb_state_t state_d;
  memarb_owner_t owner_q;

  logic [WORD_SIZE-1:0]   addr_q;
  logic [LINE_SIZE-1:0]   wdata_q;
  logic [LINE_SIZE-1:0]   rdata_q;
  logic                   we_q;
  logic                   rr_q;
  logic [MEMARB_NREQ-1:0] mask_q;

  logic [MEMARB_NREQ-1:0] cand;
  logic [MEMARB_NREQ-1:0] grant;
  logic                   rr_next;
  logic                   load;
  logic                   capture;
  logic [WORD_SIZE-1:0]   sel_addr;

  assign cand = {d_wr, d_req, i_req} & ~mask_q;

  mem_arb_pick u_pick (
    .req     (cand),
    .rr      (rr_q),
    .grant   (grant),
    .rr_next (rr_next)
  );

  // Address of the granted requester
  always_comb begin
    sel_addr = '0;
    unique case (1'b1)
      grant[REQ_DW]: sel_addr = d_wr_addr;
      grant[REQ_DR]: sel_addr = d_req_addr;
      grant[REQ_I]:  sel_addr = i_req_addr;
      default:       sel_addr = '0;
    endcase
  end

  // Next-state and load/capture strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      MEMARB_IDLE: begin
        if (|cand) begin
          state_d = MEMARB_ISSUE;
          load    = 1'b1;
        end
      end
      MEMARB_ISSUE: begin
        // zero-latency memory may finish here
        capture = mem_done;
        state_d = mem_done ? MEMARB_RESP
                           : MEMARB_WAIT;
      end
      MEMARB_WAIT: begin
        if (mem_done) begin
          capture = 1'b1;
          state_d = MEMARB_RESP;
        end
      end
      MEMARB_RESP: state_d = MEMARB_IDLE;
      default:     state_d = MEMARB_IDLE;
    endcase
  end

  // State, transaction latches, rr and mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEMARB_IDLE;
      owner_q <= MEMARB_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      rr_q    <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        owner_q <= memarb_owner_of(grant);
        addr_q  <= sel_addr;
        we_q    <= grant[REQ_DW];
        wdata_q <= grant[REQ_DW] ? d_wr_data
                                 : '0;
        rr_q    <= rr_next;
      end
      if (capture)
        rdata_q <= mem_rdata;
      // served requester sits out one idle cycle
      if (state_q == MEMARB_RESP) begin
        mask_q  <= memarb_owner_bit(owner_q);
        owner_q <= MEMARB_NONE;
      end else if (state_q == MEMARB_IDLE) begin
        mask_q <= '0;
      end
    end
  end

  assign mem_req   = (state_q == MEMARB_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_res    = (state_q == MEMARB_RESP) &&
                    (owner_q == MEMARB_IFETCH);
  assign d_res    = (state_q == MEMARB_RESP) &&
                    (owner_q == MEMARB_DREAD);
  assign d_wr_ack = (state_q == MEMARB_RESP) &&
                    (owner_q == MEMARB_DWRITE);

  assign i_res_addr = addr_q;
  assign i_res_data = rdata_q;
  assign d_res_addr = addr_q;
  assign d_res_data = rdata_q;

endmodule
